// File: rtl/pristis_sync_pkg.sv
// Shared types for the pristis sync-edge measurement blocks: FSM states,
// skew sign encoding and the default counter width used by pristis_top.
package pristis_sync_pkg;

    localparam int DEFAULT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // SIGN_POS: edge_a arrived first, so edge_b lags and the skew is positive.
    typedef enum logic {
        SIGN_POS = 1'b0,
        SIGN_NEG = 1'b1
    } sign_e;

endpackage

// File: rtl/pristis_skew_cnt.sv
// Saturating cycle counter for the skew measurement: clear, load-1 and
// increment controls, with a flag raised once the count sits at LIMIT.
module pristis_skew_cnt #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= WIDTH'(1);
        end else if (inc && cnt != LIMIT_V) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/pristis_skew_meas.sv
// Signed cycle-skew meter between two sync edges, averaged over 2^LOG2_AVG
// samples. Define PRISTIS_SKEW_MINMAX_EN to add the meas_min/meas_max outputs.
module pristis_skew_meas
    import pristis_sync_pkg::*;
#(
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int LOG2_AVG       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        edge_a,
    input  logic                        edge_b,
    output logic                        busy,
    output logic                        meas_valid,
    input  logic                        meas_ready,
    output logic signed [CNT_WIDTH-1:0] meas_cnt,
    output logic                        meas_timeout
`ifdef PRISTIS_SKEW_MINMAX_EN
    ,
    output logic signed [CNT_WIDTH-1:0] meas_min,
    output logic signed [CNT_WIDTH-1:0] meas_max
`endif
);

    localparam int ACC_WIDTH = CNT_WIDTH + LOG2_AVG;
    localparam int IDX_WIDTH = LOG2_AVG + 1;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'((1 << LOG2_AVG) - 1);
    localparam logic signed [CNT_WIDTH-1:0] TIMEOUT_POS = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic signed [CNT_WIDTH-1:0] TIMEOUT_NEG = -TIMEOUT_POS;

    state_e                       state;
    sign_e                        sign;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic        [IDX_WIDTH-1:0]  idx;

    logic                         cnt_clr;
    logic                         cnt_load1;
    logic                         cnt_inc;
    logic        [CNT_WIDTH-1:0]  cnt;
    logic                         cnt_at_limit;

    logic                         closing_edge;
    logic                         sample_done;
    logic                         timeout_hit;
    logic signed [CNT_WIDTH-1:0]  sample;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [CNT_WIDTH-1:0]  avg_trunc;

    pristis_skew_cnt #(
        .WIDTH (CNT_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load1    (cnt_load1),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .at_limit (cnt_at_limit)
    );

    // In WAIT only the channel opposite the one that opened the sample closes it.
    assign closing_edge = (sign == SIGN_POS) ? edge_b : edge_a;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_clr     = 1'b0;
        cnt_load1   = 1'b0;
        cnt_inc     = 1'b0;
        sample_done = 1'b0;
        timeout_hit = 1'b0;
        sample      = '0;
        case (state)
            ST_IDLE: cnt_clr = start;
            ST_ARM: begin
                if (edge_a && edge_b) begin
                    sample_done = 1'b1;
                    cnt_clr     = 1'b1;
                end else if (edge_a || edge_b) begin
                    cnt_load1 = 1'b1;
                end else begin
                    cnt_inc     = 1'b1;
                    timeout_hit = cnt_at_limit;
                end
            end
            ST_WAIT: begin
                if (closing_edge) begin
                    sample_done = 1'b1;
                    cnt_clr     = 1'b1;
                    sample      = (sign == SIGN_NEG) ? -$signed(cnt) : $signed(cnt);
                end else begin
                    cnt_inc     = 1'b1;
                    timeout_hit = cnt_at_limit;
                end
            end
            default: ;
        endcase
    end

    assign acc_next  = acc + ACC_WIDTH'(sample);
    // Arithmetic shift floors the average toward -inf.
    assign avg_trunc = CNT_WIDTH'(acc_next >>> LOG2_AVG);

    // NOTE: the accumulator and index are reset as well as cleared on start,
    // so an aborted run can never leak a partial sum into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sign         <= SIGN_POS;
            acc          <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            meas_valid   <= 1'b0;
            meas_cnt     <= '0;
            meas_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc          <= '0;
                        idx          <= '0;
                        meas_timeout <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_ARM;
                    end
                end
                ST_ARM, ST_WAIT: begin
                    if (sample_done) begin
                        acc <= acc_next;
                        idx <= idx + IDX_WIDTH'(1);
                        if (idx == IDX_LAST) begin
                            meas_cnt   <= avg_trunc;
                            meas_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_ARM;
                        end
                    end else if (timeout_hit) begin
                        // An ARM timeout has no sign yet and reports positive.
                        meas_cnt     <= (state == ST_WAIT && sign == SIGN_NEG) ?
                                        TIMEOUT_NEG : TIMEOUT_POS;
                        meas_timeout <= 1'b1;
                        meas_valid   <= 1'b1;
                        state        <= ST_DONE;
                    end else if (state == ST_ARM && (edge_a || edge_b)) begin
                        sign  <= edge_a ? SIGN_POS : SIGN_NEG;
                        state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (meas_ready) begin
                        meas_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PRISTIS_SKEW_MINMAX_EN
    // Extremes of the completed samples; a timed-out sample never completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_min <= '0;
            meas_max <= '0;
        end else if (sample_done) begin
            if (idx == '0) begin
                meas_min <= sample;
                meas_max <= sample;
            end else begin
                if (sample < meas_min) meas_min <= sample;
                if (sample > meas_max) meas_max <= sample;
            end
        end
    end
`endif

endmodule
